fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of issue control.
- Drives the instruction-memory read port and buffers fetched words with their PC in a small FIFO instruction queue.
- Presents the queue head to issue control as instr, instr_is_new and curr_pc.
- Redirects on an issue-time predicted-taken branch (pcmux_sel/br_pc) and on a ROB flush (flush/flush_pc).

---
 rtl/fetch_unit.sv | 158 +++++++++++++++
 tb/tb_fetch_unit.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: single outstanding memory read, small FIFO of {instr, pc+2}
// presented at the head to issue control, with branch and flush redirection.
module fetch_unit #(
   parameter int unsigned QUEUE_DEPTH = 4,
   parameter logic [15:0] RESET_PC    = 16'h0000
) (
   input  logic                          clk,
   input  logic                          rst,
   output logic [15:0]                   mem_address,
   output logic                          mem_read,
   input  logic [15:0]                   mem_rdata,
   input  logic                          mem_resp,
   output logic [15:0]                   instr,
   output logic                          instr_is_new,
   output logic [15:0]                   curr_pc,
   input  logic                          stall,
   input  logic                          pcmux_sel,
   input  logic [15:0]                   br_pc,
   input  logic                          flush,
   input  logic [15:0]                   flush_pc,
   output logic [$clog2(QUEUE_DEPTH):0]  queue_count
);

   localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WAIT    = 2'd1,
      S_DISCARD = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic               r_mem_read;
   logic [15:0]        r_fetch_pc;
   logic [15:0]        r_req_addr;
   logic [15:0]        r_q_instr [QUEUE_DEPTH];
   logic [15:0]        r_q_pc    [QUEUE_DEPTH];
   logic [PTR_W-1:0]   r_head;
   logic [PTR_W-1:0]   r_tail;
   logic [CNT_W-1:0]   r_count;

   logic               w_head_valid;
   logic               w_pop;
   logic               w_redirect;
   logic [15:0]        w_redirect_pc;
   logic [CNT_W-1:0]   w_count_after_pop;
   logic               w_push;
   logic               w_start_req;

   // Head handshake and redirect priority: flush wins over a taken branch at the head
   assign w_head_valid      = (r_count != '0);
   assign w_pop             = w_head_valid & ~stall;
   assign w_redirect        = flush | (pcmux_sel & w_pop);
   assign w_redirect_pc     = flush ? flush_pc : br_pc;
   assign w_count_after_pop = r_count - CNT_W'(w_pop);

   // Next-state and fetch control
   always_comb begin
      w_state_nxt = r_state;
      w_push      = 1'b0;
      w_start_req = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!w_redirect && (w_count_after_pop < CNT_W'(QUEUE_DEPTH))) begin
               w_start_req = 1'b1;
               w_state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (mem_resp) begin
               w_push      = ~w_redirect;
               w_state_nxt = S_IDLE;
            end else if (w_redirect) begin
               w_state_nxt = S_DISCARD;
            end
         end
         S_DISCARD: begin
            if (mem_resp) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State register; mem_read is registered alongside it
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_mem_read <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_mem_read <= (w_state_nxt != S_IDLE);
      end
   end

   // Fetch PC and the address of the read in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         r_fetch_pc <= RESET_PC;
         r_req_addr <= RESET_PC;
      end else begin
         if (w_start_req) begin
            r_req_addr <= r_fetch_pc;
         end
         if (w_redirect) begin
            r_fetch_pc <= w_redirect_pc;
         end else if (w_push) begin
            r_fetch_pc <= r_fetch_pc + 16'd2;
         end
      end
   end

   // Queue pointers and occupancy; a redirect empties the queue including this cycle's push
   always_ff @(posedge clk) begin
      if (rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (w_redirect) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_tail <= r_tail + PTR_W'(1);
         end
         if (w_pop) begin
            r_head <= r_head + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Queue storage; contents only matter while counted as valid
   always_ff @(posedge clk) begin
      if (w_push && !w_redirect) begin
         r_q_instr[r_tail] <= mem_rdata;
         r_q_pc[r_tail]    <= r_req_addr + 16'd2;
      end
   end

   assign mem_address  = r_req_addr;
   assign mem_read     = r_mem_read;
   assign instr_is_new = w_head_valid;
   assign instr        = w_head_valid ? r_q_instr[r_head] : 16'h0000;
   assign curr_pc      = w_head_valid ? r_q_pc[r_head] : 16'h0000;
   assign queue_count  = r_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: cycle model with an entry scoreboard, a table of fetch runs,
// and directed sequences for redirect, wrap and reset corners.
module tb_fetch_unit;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] mem_address;
   logic        mem_read;
   logic [15:0] mem_rdata;
   logic        mem_resp;
   logic [15:0] instr;
   logic        instr_is_new;
   logic [15:0] curr_pc;
   logic        stall;
   logic        pcmux_sel;
   logic [15:0] br_pc;
   logic        flush;
   logic [15:0] flush_pc;
   logic [2:0]  queue_count;

   fetch_unit #(.QUEUE_DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
      .clk(clk), .rst(rst),
      .mem_address(mem_address), .mem_read(mem_read),
      .mem_rdata(mem_rdata), .mem_resp(mem_resp),
      .instr(instr), .instr_is_new(instr_is_new), .curr_pc(curr_pc),
      .stall(stall), .pcmux_sel(pcmux_sel), .br_pc(br_pc),
      .flush(flush), .flush_pc(flush_pc), .queue_count(queue_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] instr;
      logic [15:0] pc;
   } entry_t;

   typedef struct {
      logic [15:0] start;
      int          lat;
      logic [7:0]  smask;
      int          npops;
      logic [15:0] last_pc;
   } vec_t;

   entry_t      sb[$];
   logic [15:0] popped[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   bit          m_out, m_disc;
   logic [15:0] m_pc, m_req;
   bit          mem_auto;
   int          mem_lat, lat_cnt;
   bit          rd_prev, rd_rise;

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      return (a * 16'd3) ^ 16'h1234;
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: timed out waiting for DUT", name);
   endtask

   // Reference behaviour for the clock edge about to happen, using the inputs now applied
   task automatic model_step();
      bit          pop, redir, resp, do_push;
      logic [15:0] tgt;
      int          sz;
      entry_t      e;
      do_push = 1'b0;
      e       = '0;
      if (rst) begin
         sb.delete();
         m_out  = 1'b0;
         m_disc = 1'b0;
         m_pc   = 16'h0000;
         m_req  = 16'h0000;
      end else begin
         sz    = sb.size();
         pop   = (sz != 0) && !stall;
         if (pop) begin
            chk("pop_instr", instr, sb[0].instr);
            chk("pop_pc", curr_pc, sb[0].pc);
            popped.push_back(sb[0].pc);
         end
         redir = flush || (pcmux_sel && pop);
         tgt   = flush ? flush_pc : br_pc;
         resp  = mem_resp && m_out;
         if (!m_out) begin
            if (!redir && ((sz - int'(pop)) < DEPTH)) begin
               m_out = 1'b1;
               m_req = m_pc;
            end
         end else if (resp) begin
            m_out = 1'b0;
            if (!m_disc && !redir) begin
               e.instr = mem_word(m_req);
               e.pc    = m_req + 16'd2;
               do_push = 1'b1;
               m_pc    = m_pc + 16'd2;
            end
            m_disc = 1'b0;
         end else if (redir) begin
            m_disc = 1'b1;
         end
         if (pop) void'(sb.pop_front());
         if (do_push) sb.push_back(e);
         if (redir) begin
            sb.delete();
            m_pc = tgt;
         end
      end
   endtask

   // Memory responder: answers a held read after mem_lat extra cycles when enabled
   task automatic mem_drive();
      if (!mem_read) begin
         lat_cnt  = 0;
         mem_resp = 1'b0;
      end else if (mem_auto && (lat_cnt >= mem_lat)) begin
         mem_resp  = 1'b1;
         mem_rdata = mem_word(mem_address);
         lat_cnt   = 0;
      end else begin
         mem_resp = 1'b0;
         lat_cnt++;
      end
   endtask

   task automatic check_outputs();
      rd_rise = mem_read && !rd_prev;
      rd_prev = mem_read;
      chk("mem_read", 16'(mem_read), 16'(m_out));
      if (m_out) chk("mem_address", mem_address, m_req);
      chk("queue_count", 16'(queue_count), 16'(sb.size()));
      chk("instr_is_new", 16'(instr_is_new), 16'(sb.size() != 0));
      if (sb.size() == 0) begin
         chk("empty_instr", instr, 16'h0000);
         chk("empty_pc", curr_pc, 16'h0000);
      end
   endtask

   task automatic cyc();
      model_step();
      @(posedge clk);
      #1;
      mem_drive();
      check_outputs();
   endtask

   task automatic wait_req(input string name, input logic [15:0] exp, input int budget);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         cyc();
         if (rd_rise) begin
            seen = 1'b1;
            chk(name, mem_address, exp);
         end
      end
      if (!seen) timeout(name);
   endtask

   task automatic wait_count(input string name, input int target, input int budget);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         cyc();
         if (int'(queue_count) == target) seen = 1'b1;
      end
      if (!seen) timeout(name);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t vecs[4];
      vecs[0] = '{16'h0200, 0, 8'h00, 5, 16'h020A};
      vecs[1] = '{16'hFFFA, 1, 8'h11, 6, 16'h0006};
      vecs[2] = '{16'h1000, 3, 8'h6C, 4, 16'h1008};
      vecs[3] = '{16'h7FF0, 2, 8'hF0, 8, 16'h8000};

      rst = 1'b1; stall = 1'b0; pcmux_sel = 1'b0; br_pc = '0;
      flush = 1'b0; flush_pc = '0; mem_resp = 1'b0; mem_rdata = '0;
      mem_auto = 1'b1; mem_lat = 0; lat_cnt = 0; rd_prev = 1'b0; rd_rise = 1'b0;
      m_out = 1'b0; m_disc = 1'b0; m_pc = '0; m_req = '0;

      // Reset values
      repeat (2) cyc();
      chk("rst_mem_read", 16'(mem_read), 16'h0000);
      chk("rst_count", 16'(queue_count), 16'h0000);
      chk("rst_instr", instr, 16'h0000);
      chk("rst_curr_pc", curr_pc, 16'h0000);
      chk("rst_is_new", 16'(instr_is_new), 16'h0000);

      // First fetch with zero-wait memory
      rst = 1'b0;
      cyc();
      chk("first_read", 16'(mem_read), 16'h0001);
      chk("first_addr", mem_address, 16'h0000);
      cyc();
      chk("first_instr", instr, 16'h1234);
      chk("first_pc", curr_pc, 16'h0002);
      chk("first_new", 16'(instr_is_new), 16'h0001);

      // Fill the queue under stall, then drain in order
      rst = 1'b1; stall = 1'b1;
      cyc();
      rst = 1'b0;
      wait_count("fill4", 4, 40);
      repeat (3) cyc();
      chk("full_no_read", 16'(mem_read), 16'h0000);
      chk("full_count", 16'(queue_count), 16'h0004);
      popped.delete();
      stall = 1'b0;
      wait_req("resume_addr", 16'h0008, 10);
      repeat (4) cyc();
      if (popped.size() >= 4) begin
         for (int i = 0; i < 4; i++) chk("drain_order", popped[i], 16'(2 * (i + 1)));
      end else timeout("drain_order");

      // Taken branch at head while the read for 0x0006 is in flight
      rst = 1'b1; stall = 1'b1;
      cyc();
      rst = 1'b0;
      wait_count("fill3", 3, 40);
      mem_auto = 1'b0;
      wait_req("br_setup", 16'h0006, 5);
      stall = 1'b0; pcmux_sel = 1'b1; br_pc = 16'h0040;
      cyc();
      pcmux_sel = 1'b0;
      chk("br_cleared", 16'(queue_count), 16'h0000);
      chk("br_hold_read", 16'(mem_read), 16'h0001);
      chk("br_hold_addr", mem_address, 16'h0006);
      repeat (2) cyc();
      chk("br_hold_addr2", mem_address, 16'h0006);
      mem_auto = 1'b1;
      wait_req("br_target", 16'h0040, 10);
      chk("br_dropped", 16'(queue_count), 16'h0000);

      // Flush beats a simultaneous branch
      rst = 1'b1; stall = 1'b1;
      cyc();
      rst = 1'b0;
      wait_count("fill2", 2, 40);
      stall = 1'b0; pcmux_sel = 1'b1; br_pc = 16'h0040; flush = 1'b1; flush_pc = 16'h0100;
      cyc();
      pcmux_sel = 1'b0; flush = 1'b0; stall = 1'b1;
      wait_req("flush_prio", 16'h0100, 10);

      // mem_resp and flush in the same WAIT cycle
      rst = 1'b1; mem_auto = 1'b0;
      cyc();
      rst = 1'b0;
      wait_req("rf_setup", 16'h0000, 5);
      flush = 1'b1; flush_pc = 16'h0300; mem_resp = 1'b1; mem_rdata = mem_word(16'h0000);
      cyc();
      flush = 1'b0;
      chk("rf_count", 16'(queue_count), 16'h0000);
      chk("rf_idle", 16'(mem_read), 16'h0000);
      mem_auto = 1'b1;
      wait_req("rf_next", 16'h0300, 10);

      // PC wrap at 0xFFFE, then reset during WAIT and a stale response
      flush = 1'b1; flush_pc = 16'hFFFE;
      cyc();
      flush = 1'b0;
      wait_count("wrap_fill", 1, 20);
      chk("wrap_pc", curr_pc, 16'h0000);
      chk("wrap_instr", instr, 16'hEDCE);
      wait_req("wrap_next", 16'h0000, 5);
      mem_auto = 1'b0;
      wait_req("wrap_next2", 16'h0002, 5);
      rst = 1'b1;
      cyc();
      chk("rst_wait_read", 16'(mem_read), 16'h0000);
      chk("rst_wait_count", 16'(queue_count), 16'h0000);
      rst = 1'b0; mem_resp = 1'b1; mem_rdata = 16'hDEAD;
      cyc();
      repeat (3) cyc();
      chk("stale_resp", 16'(queue_count), 16'h0000);

      // Table of fetch runs: start address, memory latency, stall pattern
      for (int v = 0; v < 4; v++) begin
         mem_auto = 1'b1; mem_lat = vecs[v].lat; stall = 1'b1;
         flush = 1'b1; flush_pc = vecs[v].start;
         cyc();
         flush = 1'b0;
         popped.delete();
         for (int k = 0; k < 300 && popped.size() < vecs[v].npops; k++) begin
            stall = vecs[v].smask[3'(k)];
            cyc();
         end
         if (popped.size() >= vecs[v].npops) begin
            chk("vec_first", popped[0], vecs[v].start + 16'd2);
            chk("vec_last", popped[vecs[v].npops - 1], vecs[v].last_pc);
         end else timeout("vec_run");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
